uart_rx_ctrl: RTL and testbench
===============================

Name: uart_rx_ctrl

Overview:
- Frame-sequencing controller for the UART receiver.
- Tracks oversampling edges and frame bits, and walks the frame through start, data, optional parity and stop.
- Drives the enables for the data sampler, deserializer, start checker, parity checker and stop checker, then qualifies the received byte with data_valid.
- Sits between the RX line and the RX datapath checkers in the UART_RX hierarchy.

Parameters:
DATA_WIDTH, 8, data bits per frame
PRESC_WIDTH, 6, width of the Prescale input and the edge counter

Ports:
clk  input  1  receiver oversampling clock
rst_n  input  1  asynchronous active-low reset
RX_IN  input  1  serial line; idles high
PAR_EN  input  1  1: frame carries a parity bit
Prescale  input  PRESC_WIDTH  oversampling ratio; legal values 8, 16, 32
strt_glitch  input  1  from start checker; 1 means the start bit sampled high
par_err  input  1  from parity checker
stp_err  input  1  from stop checker
dat_samp_en  output  1  enables the majority sampler
deser_en  output  1  one-cycle shift strobe to the deserializer
strt_chk_en  output  1  start checker enable
par_chk_en  output  1  parity checker enable
stp_chk_en  output  1  stop checker enable
edge_cnt  output  PRESC_WIDTH  current edge within the bit (0..P-1)
bit_cnt  output  4  current frame bit index
data_valid  output  1  one-cycle pulse; deserializer byte is good
par_err_flag  output  1  one-cycle pulse; frame dropped on parity error
stp_err_flag  output  1  one-cycle pulse; frame dropped on framing error

Behaviour:
- Clock and reset:
  - One clock, clk.
  - Reset rst_n is asynchronous and active-low.
  - On reset: state=IDLE, all outputs 0, counters 0. This applies at any time, including mid-frame.
- Prescale handling:
  - P is latched from Prescale on the IDLE->START transition and held for the whole frame. Changes mid-frame are ignored.
  - A latched value not in {8,16,32} is replaced by 8.
- Edge counter:
  - edge_cnt clears on START entry.
  - It increments every cycle in non-IDLE states and wraps P-1 -> 0.
  - On each wrap, bit_cnt increments.
  - Define "bit end" = cycle with edge_cnt==P-1.
- IDLE:
  - All enables are 0.
  - If RX_IN==0, go to START on the next edge with edge_cnt=0 and bit_cnt=0.
- START:
  - strt_chk_en=1.
  - At bit end: if strt_glitch==1, go to IDLE (silent drop, no flags); else go to DATA.
- DATA:
  - deser_en pulses at each bit end.
  - After the bit end of the DATA_WIDTH-th data bit: go to PARITY if PAR_EN==1, else STOP.
  - PAR_EN is latched with P.
- PARITY:
  - par_chk_en=1.
  - At bit end, par_err is sampled into an internal per-frame error bit, then go to STOP. The frame continues so the stop bit is consumed.
- STOP:
  - stp_chk_en=1.
  - At bit end, go to IDLE, and in the following cycle drive exactly one of:
    - data_valid, if no parity error and stp_err==0;
    - par_err_flag, if a parity error was recorded (takes priority over stp_err);
    - stp_err_flag, if there was no parity error and stp_err==1.
- Status outputs:
  - dat_samp_en=1 in every state except IDLE.
  - All flags are registered, one cycle wide, and mutually exclusive.
  - Output pulse cycle = N*P cycles after START entry, where N = 10 + PAR_EN frame bits. Example: 88 for P=8 with parity.
- Back-to-back frames: RX_IN sampled low in the IDLE cycle after a stop starts the next frame, so at most 1 cycle of start-bit skew.
- Reset during a frame: the frame is discarded, no flags are raised, and a fresh frame is accepted after reset release.

Decomposition:
- Package uart_rx_pkg holds:
  - state encoding IDLE/START/DATA/PARITY/STOP (3-bit);
  - legal prescale constants 8/16/32;
  - default prescale 8;
  - DATA_WIDTH default.
- One sub-module: edge_bit_counter.
  - Inputs: clk, rst_n, enable, latched P.
  - Outputs: edge_cnt, bit_cnt, bit_end.
  - The FSM lives in uart_rx_ctrl.

Test Plan:
- P=8, PAR_EN=1 even, frame 0xA5 with parity 0, stop 1 -> 8 deser_en pulses at bit ends; par_chk_en high for 8 cycles; data_valid one pulse 88 cycles after START entry; no error flags.
- P=8, RX_IN low for 2 cycles, strt_glitch=1 at bit end -> IDLE after 8 cycles; no deser_en; no data_valid or flags.
- P=16, PAR_EN=1, par_err forced 1 during PARITY, stop 1 -> par_err_flag pulse at cycle 176; data_valid stays 0.
- P=8, PAR_EN=0, stop bit 0 (stp_err=1) -> stp_err_flag at cycle 80; data_valid 0.
- P=32, PAR_EN=0, Prescale changed to 16 mid-DATA -> timing unaffected; data_valid at cycle 320. Second frame starting in the first IDLE cycle uses P=16, with data_valid 160 cycles later.
- rst_n pulsed low during DATA bit 3 -> all outputs 0 immediately, state IDLE; next 0x3C frame received normally with data_valid.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive controller.
//   - state_t          : 3-bit encoding of the frame-sequencing FSM
//   - PRESC_*          : legal oversampling ratios and the fallback ratio
//   - DATA_WIDTH_DEF   : default number of data bits per frame
//   - legal_prescale() : maps an arbitrary ratio onto the legal set
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    localparam int PRESC_8        = 8;
    localparam int PRESC_16       = 16;
    localparam int PRESC_32       = 32;
    localparam int PRESC_DEFAULT  = PRESC_8;
    localparam int DATA_WIDTH_DEF = 8;

    // Any ratio outside {8,16,32} falls back to the default so the
    // edge counter always has a sane wrap point.
    function automatic int legal_prescale(input int p);
        int result;
        case (p)
            PRESC_8, PRESC_16, PRESC_32: result = p;
            default:                     result = PRESC_DEFAULT;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// Oversampling edge counter and frame bit counter.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   enable     : count while high; both counters are held at 0 while low
//   prescale   : latched oversampling ratio P (wrap point of edge_cnt)
//   edge_cnt   : edge within the current bit, 0..P-1
//   bit_cnt    : frame bit index, increments on every edge_cnt wrap
//   bit_end    : edge_cnt == P-1 (last oversampling edge of a bit)
//   pre_end    : edge_cnt == P-2 (one cycle before bit_end)
module edge_bit_counter
    import uart_rx_pkg::*;
#(
    parameter int PRESC_WIDTH = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic [PRESC_WIDTH-1:0] prescale,
    output logic [PRESC_WIDTH-1:0] edge_cnt,
    output logic [3:0]             bit_cnt,
    output logic                   bit_end,
    output logic                   pre_end
);

    logic [PRESC_WIDTH-1:0] edge_cnt_r;
    logic [3:0]             bit_cnt_r;
    logic [PRESC_WIDTH-1:0] edge_last_s;
    logic [PRESC_WIDTH-1:0] edge_prelast_s;

    // Wrap points derived from the latched ratio.
    always_comb begin
        edge_last_s    = prescale - {{(PRESC_WIDTH-1){1'b0}}, 1'b1};
        edge_prelast_s = prescale - {{(PRESC_WIDTH-2){1'b0}}, 2'd2};
        bit_end        = (edge_cnt_r == edge_last_s);
        pre_end        = (edge_cnt_r == edge_prelast_s);
    end

    // Edge/bit counting; disabled means cleared so a new frame starts at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_cnt_r <= {PRESC_WIDTH{1'b0}};
            bit_cnt_r  <= 4'd0;
        end else if (!enable) begin
            edge_cnt_r <= {PRESC_WIDTH{1'b0}};
            bit_cnt_r  <= 4'd0;
        end else if (bit_end) begin
            edge_cnt_r <= {PRESC_WIDTH{1'b0}};
            bit_cnt_r  <= bit_cnt_r + 4'd1;
        end else begin
            edge_cnt_r <= edge_cnt_r + {{(PRESC_WIDTH-1){1'b0}}, 1'b1};
            bit_cnt_r  <= bit_cnt_r;
        end
    end

    assign edge_cnt = edge_cnt_r;
    assign bit_cnt  = bit_cnt_r;

endmodule

// File: rtl/uart_rx_ctrl.sv
// Frame-sequencing controller of the UART receiver.
// Walks each frame through START, DATA, optional PARITY and STOP, drives
// the checker/sampler enables and reports the frame outcome with a
// one-cycle data_valid, par_err_flag or stp_err_flag pulse in the first
// IDLE cycle after the stop bit.
// Ports:
//   clk, rst_n        : oversampling clock, asynchronous active-low reset
//   RX_IN             : serial line (idle high)
//   PAR_EN, Prescale  : frame format, latched when a start bit is seen
//   strt_glitch, par_err, stp_err : checker results
//   dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en : enables
//   edge_cnt, bit_cnt : position within the frame
//   data_valid, par_err_flag, stp_err_flag : frame outcome pulses
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int PRESC_WIDTH = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   RX_IN,
    input  logic                   PAR_EN,
    input  logic [PRESC_WIDTH-1:0] Prescale,
    input  logic                   strt_glitch,
    input  logic                   par_err,
    input  logic                   stp_err,
    output logic                   dat_samp_en,
    output logic                   deser_en,
    output logic                   strt_chk_en,
    output logic                   par_chk_en,
    output logic                   stp_chk_en,
    output logic [PRESC_WIDTH-1:0] edge_cnt,
    output logic [3:0]             bit_cnt,
    output logic                   data_valid,
    output logic                   par_err_flag,
    output logic                   stp_err_flag
);

    state_t                 state_r;
    state_t                 next_state_s;
    logic [PRESC_WIDTH-1:0] presc_r;
    logic [PRESC_WIDTH-1:0] presc_legal_s;
    logic                   par_en_r;
    logic                   par_err_r;
    logic                   cnt_en_s;
    logic                   bit_end_s;
    logic                   pre_end_s;
    logic                   frame_start_s;
    logic                   frame_done_s;
    logic                   last_data_s;

    logic dat_samp_en_r, deser_en_r, strt_chk_en_r, par_chk_en_r, stp_chk_en_r;
    logic data_valid_r, par_err_flag_r, stp_err_flag_r;

    // Counters run only while the frame stays active; leaving or entering
    // IDLE clears them, which also gives edge_cnt=0 on START entry.
    assign cnt_en_s = (state_r != ST_IDLE) && (next_state_s != ST_IDLE);

    edge_bit_counter #(
        .PRESC_WIDTH (PRESC_WIDTH)
    ) u_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (cnt_en_s),
        .prescale (presc_r),
        .edge_cnt (edge_cnt),
        .bit_cnt  (bit_cnt),
        .bit_end  (bit_end_s),
        .pre_end  (pre_end_s)
    );

    // Frame event decode and ratio sanitising.
    always_comb begin
        presc_legal_s = PRESC_WIDTH'(legal_prescale(int'(Prescale)));
        frame_start_s = (state_r == ST_IDLE) && (next_state_s == ST_START);
        frame_done_s  = (state_r == ST_STOP) && bit_end_s;
        last_data_s   = (bit_cnt == 4'(DATA_WIDTH));
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; every transition out of a bit happens at its last edge.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!RX_IN) next_state_s = ST_START;
                else        next_state_s = ST_IDLE;
            end
            ST_START: begin
                if (bit_end_s) next_state_s = strt_glitch ? ST_IDLE : ST_DATA;
                else           next_state_s = ST_START;
            end
            ST_DATA: begin
                // bit_cnt is 1..DATA_WIDTH while in DATA (START is bit 0).
                if (bit_end_s && last_data_s) next_state_s = par_en_r ? ST_PARITY : ST_STOP;
                else                          next_state_s = ST_DATA;
            end
            ST_PARITY: begin
                if (bit_end_s) next_state_s = ST_STOP;
                else           next_state_s = ST_PARITY;
            end
            ST_STOP: begin
                if (bit_end_s) next_state_s = ST_IDLE;
                else           next_state_s = ST_STOP;
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Frame format is captured once per frame so mid-frame changes are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_r  <= PRESC_WIDTH'(PRESC_DEFAULT);
            par_en_r <= 1'b0;
        end else if (frame_start_s) begin
            presc_r  <= presc_legal_s;
            par_en_r <= PAR_EN;
        end else begin
            presc_r  <= presc_r;
            par_en_r <= par_en_r;
        end
    end

    // Per-frame parity error memory; the frame still runs to its stop bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_err_r <= 1'b0;
        end else if (frame_start_s) begin
            par_err_r <= 1'b0;
        end else if ((state_r == ST_PARITY) && bit_end_s) begin
            par_err_r <= par_err;
        end else begin
            par_err_r <= par_err_r;
        end
    end

    // Registered enables, aligned with the state they belong to. deser_en
    // is loaded one edge early so it lands exactly on each data bit end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dat_samp_en_r <= 1'b0;
            deser_en_r    <= 1'b0;
            strt_chk_en_r <= 1'b0;
            par_chk_en_r  <= 1'b0;
            stp_chk_en_r  <= 1'b0;
        end else begin
            dat_samp_en_r <= (next_state_s != ST_IDLE);
            deser_en_r    <= (state_r == ST_DATA) && pre_end_s;
            strt_chk_en_r <= (next_state_s == ST_START);
            par_chk_en_r  <= (next_state_s == ST_PARITY);
            stp_chk_en_r  <= (next_state_s == ST_STOP);
        end
    end

    // Outcome pulses; parity error has priority over a framing error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_valid_r   <= 1'b0;
            par_err_flag_r <= 1'b0;
            stp_err_flag_r <= 1'b0;
        end else if (frame_done_s) begin
            data_valid_r   <= !par_err_r && !stp_err;
            par_err_flag_r <= par_err_r;
            stp_err_flag_r <= !par_err_r && stp_err;
        end else begin
            data_valid_r   <= 1'b0;
            par_err_flag_r <= 1'b0;
            stp_err_flag_r <= 1'b0;
        end
    end

    assign dat_samp_en  = dat_samp_en_r;
    assign deser_en     = deser_en_r;
    assign strt_chk_en  = strt_chk_en_r;
    assign par_chk_en   = par_chk_en_r;
    assign stp_chk_en   = stp_chk_en_r;
    assign data_valid   = data_valid_r;
    assign par_err_flag = par_err_flag_r;
    assign stp_err_flag = stp_err_flag_r;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl. Cycle 0 of a frame is the first cycle
// with the FSM in START; outputs are sampled on the falling clock edge.
module tb_uart_rx_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       RX_IN;
    logic       PAR_EN;
    logic [5:0] Prescale;
    logic       strt_glitch;
    logic       par_err;
    logic       stp_err;
    logic       dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en;
    logic [5:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       data_valid, par_err_flag, stp_err_flag;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    // Frame observation results
    int n_deser, deser_ok, n_par, n_strt, n_stp;
    int dv_c, pef_c, sef_c, n_dv, n_pef, n_sef, idle_c;

    uart_rx_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .RX_IN        (RX_IN),
        .PAR_EN       (PAR_EN),
        .Prescale     (Prescale),
        .strt_glitch  (strt_glitch),
        .par_err      (par_err),
        .stp_err      (stp_err),
        .dat_samp_en  (dat_samp_en),
        .deser_en     (deser_en),
        .strt_chk_en  (strt_chk_en),
        .par_chk_en   (par_chk_en),
        .stp_chk_en   (stp_chk_en),
        .edge_cnt     (edge_cnt),
        .bit_cnt      (bit_cnt),
        .data_valid   (data_valid),
        .par_err_flag (par_err_flag),
        .stp_err_flag (stp_err_flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at a falling edge while idle: drops RX_IN to start a frame and
    // observes it. p is the ratio the frame is expected to use. With b2b
    // set, returns at the falling edge where data_valid is seen.
    task automatic run_frame(input int p, input int pe, input int b2b,
                             input int chg_at, input int chg_val);
        int lim;
        lim = (10 + pe) * p + 4;
        n_deser = 0; deser_ok = 0; n_par = 0; n_strt = 0; n_stp = 0;
        dv_c = -1; pef_c = -1; sef_c = -1; n_dv = 0; n_pef = 0; n_sef = 0;
        idle_c = -1;
        RX_IN = 1'b0;
        @(negedge clk);
        for (int c = 0; c < lim; c++) begin
            if (deser_en) n_deser++;
            if (deser_en && (c % p) == p - 1 && c / p >= 1 && c / p <= 8) deser_ok++;
            if (par_chk_en)  n_par++;
            if (strt_chk_en) n_strt++;
            if (stp_chk_en)  n_stp++;
            if (data_valid)   begin n_dv++;  dv_c  = c; end
            if (par_err_flag) begin n_pef++; pef_c = c; end
            if (stp_err_flag) begin n_sef++; sef_c = c; end
            if (!dat_samp_en && idle_c < 0 && c > 0) idle_c = c;
            if (c == 1) RX_IN = 1'b1;
            if (c == chg_at) Prescale = 6'(chg_val);
            if (b2b != 0 && data_valid) break;
            @(negedge clk);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_samp"}, int'(dat_samp_en), 0);
        chk({tag, "_strobes"}, int'({deser_en, strt_chk_en, par_chk_en, stp_chk_en}), 0);
        chk({tag, "_flags"}, int'({data_valid, par_err_flag, stp_err_flag}), 0);
        chk({tag, "_cnts"}, int'({edge_cnt, bit_cnt}), 0);
    endtask

    initial begin
        rst_n = 1'b0; RX_IN = 1'b1; PAR_EN = 1'b0; Prescale = 6'd8;
        strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk_idle_outputs("idle_after_reset");

        // 1: P=8 with parity, clean frame
        PAR_EN = 1'b1; Prescale = 6'd8;
        run_frame(8, 1, 0, -1, 0);
        chk("t1_deser_cnt", n_deser, 8);
        chk("t1_deser_at_end", deser_ok, 8);
        chk("t1_par_chk_len", n_par, 8);
        chk("t1_strt_chk_len", n_strt, 8);
        chk("t1_stp_chk_len", n_stp, 8);
        chk("t1_dv_cycle", dv_c, 88);
        chk("t1_dv_count", n_dv, 1);
        chk("t1_err_flags", n_pef + n_sef, 0);
        chk("t1_idle_cycle", idle_c, 88);

        // 2: start glitch drops the frame silently
        PAR_EN = 1'b0; strt_glitch = 1'b1;
        run_frame(8, 0, 0, -1, 0);
        strt_glitch = 1'b0;
        chk("t2_idle_cycle", idle_c, 8);
        chk("t2_strt_chk_len", n_strt, 8);
        chk("t2_deser_cnt", n_deser, 0);
        chk("t2_any_pulse", n_dv + n_pef + n_sef, 0);

        // 3: P=16 parity error, good stop bit
        PAR_EN = 1'b1; Prescale = 6'd16; par_err = 1'b1;
        run_frame(16, 1, 0, -1, 0);
        par_err = 1'b0;
        chk("t3_pef_cycle", pef_c, 176);
        chk("t3_pef_count", n_pef, 1);
        chk("t3_dv_count", n_dv, 0);
        chk("t3_sef_count", n_sef, 0);
        chk("t3_deser_at_end", deser_ok, 8);

        // 3b: parity error wins over a simultaneous framing error
        par_err = 1'b1; stp_err = 1'b1;
        run_frame(16, 1, 0, -1, 0);
        par_err = 1'b0; stp_err = 1'b0;
        chk("t3b_pef_cycle", pef_c, 176);
        chk("t3b_other", n_dv + n_sef, 0);

        // 4: P=8 no parity, framing error
        PAR_EN = 1'b0; Prescale = 6'd8; stp_err = 1'b1;
        run_frame(8, 0, 0, -1, 0);
        stp_err = 1'b0;
        chk("t4_sef_cycle", sef_c, 80);
        chk("t4_sef_count", n_sef, 1);
        chk("t4_dv_count", n_dv, 0);
        chk("t4_par_chk_len", n_par, 0);

        // 4b: illegal ratio 12 falls back to 8
        Prescale = 6'd12;
        run_frame(8, 0, 0, -1, 0);
        chk("t4b_dv_cycle", dv_c, 80);
        chk("t4b_deser_at_end", deser_ok, 8);

        // 5: P=32, ratio changed to 16 mid-DATA; then back-to-back frame at 16
        Prescale = 6'd32;
        run_frame(32, 0, 1, 100, 16);
        chk("t5_dv_cycle", dv_c, 320);
        chk("t5_deser_at_end", deser_ok, 8);
        run_frame(16, 0, 0, -1, 0);
        chk("t5_b2b_dv_cycle", dv_c, 160);
        chk("t5_b2b_dv_count", n_dv, 1);
        chk("t5_b2b_deser_at_end", deser_ok, 8);

        // 6: reset in DATA bit 3, then a normal 0x3C frame
        Prescale = 6'd8;
        RX_IN = 1'b0;
        @(negedge clk);
        RX_IN = 1'b1;
        repeat (28) @(negedge clk);
        chk("t6_bit_before_reset", int'(bit_cnt), 3);
        chk("t6_samp_before_reset", int'(dat_samp_en), 1);
        rst_n = 1'b0;
        #1;
        chk_idle_outputs("t6_async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk_idle_outputs("t6_after_release");
        run_frame(8, 0, 0, -1, 0);
        chk("t6_dv_cycle", dv_c, 80);
        chk("t6_dv_count", n_dv, 1);
        chk("t6_deser_cnt", n_deser, 8);
        chk("t6_err_flags", n_pef + n_sef, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
